// File: rtl/fp_sqrt_seq.sv
// fp_sqrt_seq: sequential IEEE-754 single-precision square root.
// The operand is unpacked and classified, and its exponent is halved. A
// non-restoring digit recurrence then produces one root bit per cycle. The
// result is rounded to nearest-even and returned over a valid/ready handshake.
// Optional feature macro: FP_SQRT_SUBNORM_EN. When it is defined, subnormal
// operands are normalised with a leading-zero count. When it is undefined,
// they are flushed to a signed zero.
module fp_sqrt_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] out_data,
  output logic [1:0]            out_flags,
  output logic                  busy
);

  localparam int WORD_W = EXP_W + MANT_W + 1;
  localparam int SIG_W  = MANT_W + 1;       // 1.f significand
  localparam int ROOT_W = MANT_W + 2;       // 1.f root plus guard bit
  localparam int RAD_W  = 2 * ROOT_W;       // two radicand bits per root bit
  localparam int REM_W  = ROOT_W + 2;       // two's-complement partial remainder
  localparam int EW2    = EXP_W + 2;        // signed unbiased exponent
  localparam int CNT_W  = $clog2(ROOT_W + 1);

  localparam logic [WORD_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [WORD_W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};

`ifdef FP_SQRT_SUBNORM_EN
  localparam bit SUB_EN = 1'b1;
  localparam int LZW    = $clog2(MANT_W + 1);

  // Count the leading zeros of the stored fraction. Only subnormals use this.
  function automatic logic [LZW-1:0] lzc(input logic [MANT_W-1:0] f);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (f[i]) found = 1'b1;
        else      lzc   = lzc + LZW'(1);
      end
    end
  endfunction
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;

  state_t              state;
  logic [WORD_W-1:0]   op;
  logic [RAD_W-1:0]    rad;
  logic [REM_W-1:0]    rem;
  logic [ROOT_W-1:0]   root;
  logic [CNT_W-1:0]    cnt;
  logic [EXP_W-1:0]    res_exp;

  // Operand fields and classification
  logic                op_sign;
  logic [EXP_W-1:0]    op_exp;
  logic [MANT_W-1:0]   op_frac;
  logic                exp_max, exp_zero, frac_zero;

  assign op_sign   = op[WORD_W-1];
  assign op_exp    = op[WORD_W-2 -: EXP_W];
  assign op_frac   = op[MANT_W-1:0];
  assign exp_max   = &op_exp;
  assign exp_zero  = ~|op_exp;
  assign frac_zero = ~|op_frac;

  logic                sp_hit;
  logic [WORD_W-1:0]   sp_data;
  logic [1:0]          sp_flags;

  // Special-case classification: NaN, zero/flushed subnormal, negative, +inf.
  always_comb begin
    // NOTE: every output of a combinational block is given a default first, so no path through the if-chain can infer a latch.
    sp_hit   = 1'b1;
    sp_data  = '0;
    sp_flags = 2'b00;
    if (exp_max && !frac_zero) begin
      sp_data  = QNAN;
      sp_flags = {~op_frac[MANT_W-1], 1'b0};
    end else if (exp_zero && (frac_zero || !SUB_EN)) begin
      sp_data = {op_sign, {(WORD_W-1){1'b0}}};
    end else if (op_sign) begin
      sp_data  = QNAN;
      sp_flags = 2'b10;
    end else if (exp_max) begin
      sp_data = PINF;
    end else begin
      sp_hit = 1'b0;
    end
  end

  // Normalisation: significand, even-exponent alignment, radicand.
  logic [SIG_W-1:0]        sig;
  logic signed [EW2-1:0]   e_unb, e_half;
  logic [ROOT_W-1:0]       sig_adj;
  logic [RAD_W-1:0]        pr_rad;
  logic [EXP_W-1:0]        pr_exp;
`ifdef FP_SQRT_SUBNORM_EN
  logic [LZW-1:0]          lz;
`endif

  // Form 1.f and the unbiased exponent. An odd exponent moves one bit into the significand.
  always_comb begin
    sig   = {1'b1, op_frac};
    e_unb = $signed({2'b00, op_exp}) - EW2'(BIAS);
`ifdef FP_SQRT_SUBNORM_EN
    lz = lzc(op_frac);
    if (exp_zero) begin
      sig   = {1'b0, op_frac} << (lz + LZW'(1));
      e_unb = EW2'(1 - BIAS) - EW2'(lz) - EW2'(1);
    end
`endif
    e_half  = e_unb >>> 1;
    sig_adj = e_unb[0] ? {sig, 1'b0} : {1'b0, sig};
    pr_rad  = {sig_adj, {ROOT_W{1'b0}}};
    pr_exp  = EXP_W'(e_half + EW2'(BIAS));
  end

  // One non-restoring step: the remainder sign picks subtract or add, and the new sign gives the root bit.
  logic [REM_W-1:0]  rem_sh, rem_next;
  logic [ROOT_W-1:0] root_next;

  assign rem_sh    = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
  assign rem_next  = rem[REM_W-1] ? rem_sh + {root, 2'b11} : rem_sh - {root, 2'b01};
  assign root_next = {root[ROOT_W-2:0], ~rem_next[REM_W-1]};

  // Rounding: correct a negative final remainder, then round the 1.f root to nearest-even using its guard bit.
  logic [REM_W-1:0]  rem_fix;
  logic              sticky, round_up, inexact;
  logic [SIG_W-1:0]  frac_sum;
  logic [EXP_W-1:0]  rnd_exp;
  logic [WORD_W-1:0] rnd_data;

  assign rem_fix  = rem[REM_W-1] ? rem + REM_W'({root, 1'b1}) : rem;
  assign sticky   = |rem_fix;
  assign round_up = root[0] & (sticky | root[1]);
  assign frac_sum = {1'b0, root[MANT_W:1]} + SIG_W'(round_up);
  assign rnd_exp  = res_exp + EXP_W'(frac_sum[MANT_W]);
  assign rnd_data = {1'b0, rnd_exp, frac_sum[MANT_W-1:0]};
  assign inexact  = root[0] | sticky;

  // Control FSM with registered handshake outputs, plus the iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= 2'b00;
      // NOTE: the datapath registers are reset as well, so an aborted operation leaves no stale operand or partial root behind.
      op        <= '0;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      cnt       <= '0;
      res_exp   <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments, so every register samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op       <= in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          if (sp_hit) begin
            out_data  <= sp_data;
            out_flags <= sp_flags;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rad     <= pr_rad;
            rem     <= '0;
            root    <= '0;
            cnt     <= CNT_W'(ROOT_W);
            res_exp <= pr_exp;
            state   <= ITER;
          end
        end
        ITER: begin
          rad  <= rad << 2;
          rem  <= rem_next;
          root <= root_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ROUND;
        end
        ROUND: begin
          out_data  <= rnd_data;
          out_flags <= {1'b0, inexact};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// tb_fp_sqrt_seq: self-checking bench for fp_sqrt_seq. Expected results come
// from an integer square-root model of IEEE-754 single precision with
// round-to-nearest-even.
module tb_fp_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_flags;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam int TMO = 100;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] d;
    logic [1:0]  f;
    logic [5:0]  lat;
  } vec_t;

`ifdef FP_SQRT_SUBNORM_EN
  localparam vec_t SUB_VEC = {32'h00000001, 32'h1A3504F3, 2'b01, 6'd28};
`else
  localparam vec_t SUB_VEC = {32'h00000001, 32'h00000000, 2'b00, 6'd2};
`endif

  always #5 clk = ~clk;

  fp_sqrt_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .busy      (busy)
  );

  // Reference: classify, then take the exact integer square root of the scaled significand and round to nearest-even.
  task automatic ref_sqrt(input logic [31:0] x, output logic [31:0] d, output logic [1:0] f, output int lat);
    logic s;
    logic [7:0] ex;
    logic [22:0] fr;
    int e;
    longint m, r, q, rm, sg;
    s = x[31]; ex = x[30:23]; fr = x[22:0];
    f = 2'b00; lat = 2; d = '0;
    if (ex == 8'hFF && fr != 0) begin
      d = 32'h7FC00000; f = {~fr[22], 1'b0};
    end else if (ex == 0 && fr == 0) begin
      d = {s, 31'b0};
`ifndef FP_SQRT_SUBNORM_EN
    end else if (ex == 0) begin
      d = {s, 31'b0};
`endif
    end else if (s) begin
      d = 32'h7FC00000; f = 2'b10;
    end else if (ex == 8'hFF) begin
      d = 32'h7F800000;
    end else begin
      lat = 28;
      if (ex == 0) begin
        m = longint'(fr); e = -126;
        while (m < (longint'(1) << 23)) begin m = m << 1; e--; end
      end else begin
        m = (longint'(1) << 23) + longint'(fr); e = int'(ex) - 127;
      end
      if ((e & 1) != 0) begin m = m << 1; e = e - 1; end
      r = m << 25;
      q = longint'($sqrt(real'(r)));
      while (q * q > r) q--;
      while ((q + 1) * (q + 1) <= r) q++;
      rm = r - q * q;
      sg = q >> 1;
      if ((q & 1) == 1 && (rm != 0 || (sg & 1) == 1)) sg++;
      e = e / 2 + 127;
      if (sg == (longint'(1) << 24)) begin sg = sg >> 1; e++; end
      d = {1'b0, 8'(e), 23'(sg)};
      f = {1'b0, ((q & 1) == 1) || (rm != 0)};
    end
  endtask

  // Wait for in_ready, present x, and return just after the accepting edge.
  task automatic start_op(input logic [31:0] x);
    int c = 0;
    while (!in_ready && c < TMO) begin @(posedge clk); #1; c++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_timeout in_ready=%b required=1", in_ready);
    end
    in_data = x; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from acceptance to the first edge where the result can be taken; scramble in_data meanwhile.
  task automatic wait_result(output logic [31:0] d, output logic [1:0] f, output int lat);
    int c = 0;
    while (!out_valid && c < TMO) begin @(posedge clk); #1; in_data = $urandom; c++; end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL result_timeout out_valid=%b required=1", out_valid);
    end
    d = out_data; f = out_flags; lat = c + 1;
  endtask

  task automatic run_op(input logic [31:0] x, output logic [31:0] d, output logic [1:0] f, output int lat);
    out_ready = 1'b1;
    start_op(x);
    wait_result(d, f, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    total++; if (out_flags !== 2'b00) begin bad++; $display("FAIL rst_out_flags got=%b want=00", out_flags); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_directed();
    vec_t dv [11];
    logic [31:0] d;
    logic [1:0] f;
    int lat;
    dv = '{{32'h40800000, 32'h40000000, 2'b00, 6'd28},
           {32'h40000000, 32'h3FB504F3, 2'b01, 6'd28},
           {32'h3F800000, 32'h3F800000, 2'b00, 6'd28},
           {32'hC0800000, 32'h7FC00000, 2'b10, 6'd2},
           {32'h7F800000, 32'h7F800000, 2'b00, 6'd2},
           {32'h80000000, 32'h80000000, 2'b00, 6'd2},
           {32'h7F800001, 32'h7FC00000, 2'b10, 6'd2},
           {32'h7FC00000, 32'h7FC00000, 2'b00, 6'd2},
           {32'hFF800000, 32'h7FC00000, 2'b10, 6'd2},
           {32'h407FFFFF, 32'h3FFFFFFF, 2'b01, 6'd28},
           SUB_VEC};
    foreach (dv[i]) begin
      run_op(dv[i].x, d, f, lat);
      total++; if (d !== dv[i].d) begin bad++; $display("FAIL dir_data x=%h got=%h want=%h", dv[i].x, d, dv[i].d); end
      total++; if (f !== dv[i].f) begin bad++; $display("FAIL dir_flags x=%h got=%b want=%b", dv[i].x, f, dv[i].f); end
      total++; if (lat !== int'(dv[i].lat)) begin bad++; $display("FAIL dir_latency x=%h got=%0d want=%0d", dv[i].x, lat, dv[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, d, ed;
    logic [1:0] f, ef;
    int lat, el;
    for (int i = 0; i < 80; i++) begin
      case (i)
        0: x = 32'h7F7FFFFF;
        1: x = 32'h00800000;
        2: x = 32'h007FFFFF;
        3: x = 32'h807FFFFF;
        default: begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            6: x = $urandom;
            7: x = {1'($urandom), 8'hFF, 23'($urandom_range(0, 3)) << 21};
            8: x = {1'($urandom), 8'h00, 23'($urandom)};
            default: x = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
          endcase
        end
      endcase
      ref_sqrt(x, ed, ef, el);
      run_op(x, d, f, lat);
      total++; if (d !== ed) begin bad++; $display("FAIL rnd_data x=%h got=%h want=%h", x, d, ed); end
      total++; if (f !== ef) begin bad++; $display("FAIL rnd_flags x=%h got=%b want=%b", x, f, ef); end
      total++; if (lat !== el) begin bad++; $display("FAIL rnd_latency x=%h got=%0d want=%0d", x, lat, el); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, ed;
    logic [1:0] f, ef;
    int lat, el;
    out_ready = 1'b0;
    start_op(32'h40000000);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_drop got=%b want=0", in_ready); end
    wait_result(d, f, lat);
    ref_sqrt(32'h40000000, ed, ef, el);
    total++; if (d !== ed || f !== ef || lat !== el) begin
      bad++; $display("FAIL bp_result got=%h/%b/%0d want=%h/%b/%0d", d, f, lat, ed, ef, el);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_data = $urandom;
      total++; if (out_valid !== 1'b1 || out_data !== d || out_flags !== f) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b want=1/%h/%b", i, out_valid, out_data, out_flags, d, f);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_transfer out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_back got=%b want=1", in_ready); end
    in_data = 32'h40800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept in_ready=%b busy=%b want=0/1", in_ready, busy);
    end
    wait_result(d, f, lat);
    @(posedge clk); #1;
    total++; if (d !== 32'h40000000 || f !== 2'b00 || lat !== 28) begin
      bad++; $display("FAIL b2b_result got=%h/%b/%0d want=40000000/00/28", d, f, lat);
    end
  endtask

  task automatic test_reset_mid_iter();
    logic [31:0] d;
    logic [1:0] f;
    int lat;
    out_ready = 1'b1;
    start_op(32'h40000000);
    repeat (9) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_busy busy=%b out_valid=%b want=1/0", busy, out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL mid_rst_out_data got=%h want=0", out_data); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_release in_ready=%b out_valid=%b want=1/0", in_ready, out_valid);
    end
    run_op(32'h40800000, d, f, lat);
    total++; if (d !== 32'h40000000 || f !== 2'b00 || lat !== 28) begin
      bad++; $display("FAIL mid_after got=%h/%b/%0d want=40000000/00/28", d, f, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_iter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fp_sqrt_seq.md
Name: fp_sqrt_seq

Overview:
- Sequential IEEE-754 single-precision square-root unit for the floating_point_alu.
- Unpacks the operand, normalises it and halves the exponent.
- Runs a non-restoring digit-recurrence loop, one root bit per cycle. The per-step root-bit decision is taken from the sign of the partial remainder (the square_root bit-decision logic).
- Rounds to nearest-even and returns the packed result over a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored fraction width.
- BIAS, 127, exponent bias.
- Only the defaults are verified.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operand valid.
- in_ready  output  1  unit can accept an operand (high only in IDLE).
- in_data  input  32  operand {sign, exp, frac}.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  packed result.
- out_flags  output  2  {invalid, inexact}; valid with out_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - in_ready=1 once rst_n is high; busy=0.
  - out_valid=0, out_data=0, out_flags=0.
  - Datapath registers cleared to 0.
- Asserting rst_n mid-operation aborts the operation immediately. No partial result is ever presented.
- States are IDLE, PREP, ITER, ROUND, DONE.
- IDLE: on in_valid & in_ready, latch in_data and go to PREP. in_ready drops on the following cycle.
- PREP (1 cycle), special-case classification. Special results go straight to DONE:
  - NaN input -> 0x7FC00000; invalid=1 only if the input is signalling (frac[22]=0).
  - Negative non-zero input (including -inf) -> 0x7FC00000, invalid=1.
  - ±0 -> ±0; +inf -> +inf; flags 0.
- PREP, normal and subnormal operands:
  - Form significand 1.f.
  - Subnormals are handled per the optional feature.
  - Unbiased exponent e = E - BIAS. If e is odd, shift the significand left 1 and set e = e - 1.
  - Result exponent = e/2 + BIAS (arithmetic shift).
  - Load a 50-bit radicand, clear the remainder and root, set the iteration counter to 25, go to ITER.
- ITER (25 cycles):
  - Each cycle consumes 2 radicand bits.
  - If the remainder is >= 0: subtract (root<<2 | 01). Otherwise: add (root<<2 | 11).
  - New root bit = NOT sign(new remainder).
  - The counter decrements; at 0 go to ROUND.
  - The remainder is signed, 27 bits wide, and must not overflow.
- ROUND (1 cycle):
  - Root bits [24:1] form the 1.23 significand; bit 0 is the guard.
  - sticky = (final remainder != 0) after sign correction.
  - Round up if guard & (sticky | lsb).
  - A significand carry-out increments the exponent and zeroes the fraction.
  - inexact = guard | sticky.
- DONE:
  - out_valid=1; out_data and out_flags are held stable until out_valid & out_ready.
  - Then return to IDLE; in_ready=1 on the next cycle.
  - If out_ready is already high on entry, the result is transferred in its first DONE cycle.
- Latency, counted from the accepting edge:
  - Normal operands: out_valid rises 28 cycles later (PREP 1 + ITER 25 + ROUND 1, then DONE).
  - Special operands: out_valid rises 2 cycles later.
- Throughput: one operation at a time. in_ready is low during PREP..DONE.
- in_data changes while busy are ignored.

Optional Feature:
- Macro: FP_SQRT_SUBNORM_EN.
- Defined:
  - Subnormal inputs are normalised in PREP with a leading-zero count. Shift the fraction left by lzc+1 and set e = 1 - BIAS - (lzc+1).
  - Processing then continues as for normal operands, with the same latency.
- Undefined:
  - Subnormal inputs are flushed to a zero of the input sign, with flags 0.
  - They take the special-case path, with latency 2.
  - The leading-zero logic is not built.

Test Plan:
- Exact square: in_data 0x40800000 (4.0) -> out_data 0x40000000, flags 00, out_valid exactly 28 cycles after acceptance.
- Inexact, odd exponent: 0x40000000 (2.0) -> 0x3FB504F3, flags 01. Then 0x3F800000 -> 0x3F800000, flags 00.
- Specials:
  - 0xC0800000 -> 0x7FC00000, flags 10, latency 2.
  - 0x7F800000 -> 0x7F800000, flags 00.
  - 0x80000000 -> 0x80000000, flags 00.
  - 0x7F800001 -> 0x7FC00000, flags 10.
- Subnormal 0x00000001:
  - With FP_SQRT_SUBNORM_EN -> 0x1A3504F3, flags 01, latency 28.
  - Without FP_SQRT_SUBNORM_EN -> 0x00000000, flags 00, latency 2.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises.
  - out_data and out_flags stay stable; in_ready stays 0.
  - Raise out_ready: transfer in that cycle, in_ready=1 on the next cycle, and a back-to-back operand is accepted.
- Reset mid-ITER: pull rst_n low at cycle 10 of a 2.0 operation.
  - out_valid=0, busy=0, out_data=0 immediately.
  - After release, 4.0 -> 0x40000000 with correct latency.
